// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared definitions for the UART transmit serializer slice.
//   DATA_W_DEF : default payload width per frame
//   state_t    : frame state encoding (IDLE, START, DATA, PARITY, STOP)
//   LINE_IDLE  : serial line idle / stop level
//   START_BIT  : serial line start level
package uart_tx_pkg;

    localparam int unsigned DATA_W_DEF = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;

endpackage

// File: rtl/uart_tx_serializer_if.sv
// uart_tx_serializer_if: byte request, parity input and serial outputs of the
// UART transmit serializer.
//   P_DATA     : byte to transmit
//   DATA_VALID : request to send P_DATA
//   PAR_EN     : insert a parity bit in this frame
//   par_bit    : parity value from the parity calculator
//   TX_OUT     : serial line
//   BUSY       : frame in progress
// master drives the request side, slave is the serializer.
interface uart_tx_serializer_if #(
    parameter int unsigned DATA_W = uart_tx_pkg::DATA_W_DEF
);

    logic [DATA_W-1:0] P_DATA;
    logic              DATA_VALID;
    logic              PAR_EN;
    logic              par_bit;
    logic              TX_OUT;
    logic              BUSY;

    modport master (
        output P_DATA, DATA_VALID, PAR_EN, par_bit,
        input  TX_OUT, BUSY
    );

    modport slave (
        input  P_DATA, DATA_VALID, PAR_EN, par_bit,
        output TX_OUT, BUSY
    );

endinterface

// File: rtl/uart_tx_mux.sv
// uart_tx_mux: combinational selection of the serial line level for a state.
//   state    : frame state the line level is wanted for
//   data_bit : current data bit (LSB of the shift register)
//   par_bit  : parity value
//   line_c   : selected line level (registered by the caller)
module uart_tx_mux
    import uart_tx_pkg::*;
(
    input  state_t state,
    input  logic   data_bit,
    input  logic   par_bit,
    output logic   line_c
);

    always_comb begin
        line_c = LINE_IDLE;
        unique case (state)
            IDLE:    line_c = LINE_IDLE;
            START:   line_c = START_BIT;
            DATA:    line_c = data_bit;
            PARITY:  line_c = par_bit;
            STOP:    line_c = LINE_IDLE;
            default: line_c = LINE_IDLE;
        endcase
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: UART transmit frame controller and serializer.
// Sends start bit, DATA_W data bits LSB-first, optional parity, stop bit,
// one bit per CLK (baud clock).
//   CLK  : baud clock, rising edge
//   RST  : asynchronous active-low reset
//   bus  : uart_tx_serializer_if.slave (P_DATA, DATA_VALID, PAR_EN, par_bit
//          in; TX_OUT, BUSY out, both registered)
// Build option: define UART_TX_TWO_STOP_EN for two stop bits per frame.
module uart_tx_serializer
    import uart_tx_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic                  CLK,
    input  logic                  RST,
    uart_tx_serializer_if.slave   bus
);

    localparam int unsigned     CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] shift;
    logic [DATA_W-1:0] shift_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              par_en_q;
    logic              par_en_nxt;
    logic              tx_q;
    logic              busy_q;
    logic              line_c;
`ifdef UART_TX_TWO_STOP_EN
    logic              stop_cnt;
    logic              stop_cnt_nxt;
`endif

    // Next-state, shift register and counter update
    always_comb begin
        state_nxt  = state;
        shift_nxt  = shift;
        cnt_nxt    = cnt;
        par_en_nxt = par_en_q;
`ifdef UART_TX_TWO_STOP_EN
        stop_cnt_nxt = stop_cnt;
`endif
        case (state)
            IDLE: begin
                if (bus.DATA_VALID) begin
                    state_nxt  = START;
                    shift_nxt  = bus.P_DATA;
                    par_en_nxt = bus.PAR_EN;
                    cnt_nxt    = '0;
                end
            end
            START: state_nxt = DATA;
            DATA: begin
                // shift[0] is the bit on the line; advance only between bits
                if (cnt == CNT_LAST) begin
                    state_nxt = par_en_q ? PARITY : STOP;
                end else begin
                    shift_nxt = shift >> 1;
                    cnt_nxt   = cnt + CNT_W'(1);
                end
            end
            PARITY: state_nxt = STOP;
            STOP: begin
`ifdef UART_TX_TWO_STOP_EN
                // stop_cnt returns to 0 on exit, so it is clear on each entry
                if (stop_cnt) begin
                    state_nxt    = IDLE;
                    stop_cnt_nxt = 1'b0;
                end else begin
                    stop_cnt_nxt = 1'b1;
                end
`else
                state_nxt = IDLE;
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Line level is chosen for the state being entered so TX_OUT is registered
    uart_tx_mux u_mux (
        .state    (state_nxt),
        .data_bit (shift_nxt[0]),
        .par_bit  (bus.par_bit),
        .line_c   (line_c)
    );

    // State and output registers
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= IDLE;
            shift    <= '0;
            cnt      <= '0;
            par_en_q <= 1'b0;
            tx_q     <= LINE_IDLE;
            busy_q   <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
            stop_cnt <= 1'b0;
`endif
        end else begin
            state    <= state_nxt;
            shift    <= shift_nxt;
            cnt      <= cnt_nxt;
            par_en_q <= par_en_nxt;
            tx_q     <= line_c;
            busy_q   <= (state_nxt != IDLE);
`ifdef UART_TX_TWO_STOP_EN
            stop_cnt <= stop_cnt_nxt;
`endif
        end
    end

    assign bus.TX_OUT = tx_q;
    assign bus.BUSY   = busy_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: directed plus randomized frames checked cycle by
// cycle against an expected bit list built from the frame format.
module tb_uart_tx_serializer;
    import uart_tx_pkg::*;

    localparam int unsigned DW = DATA_W_DEF;

    logic CLK = 1'b0;
    logic RST = 1'b0;

    uart_tx_serializer_if #(.DATA_W(DW)) bus ();

    uart_tx_serializer #(.DATA_W(DW)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_idle(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            check($sformatf("%s idle_tx[%0d]", tag, i), bus.TX_OUT, 1'b1);
            check($sformatf("%s idle_busy[%0d]", tag, i), bus.BUSY, 1'b0);
        end
    endtask

    // Expected line: start, data LSB-first, optional parity, stop bit(s).
    // Acceptance happens on the first edge after the call.
    task automatic send_frame(input logic [DW-1:0] d, input logic pe,
                              input logic pb, input logic scramble,
                              input logic hold, input string name);
        logic exp_q[$];
        exp_q.push_back(1'b0);
        for (int i = 0; i < int'(DW); i++) exp_q.push_back(d[i]);
        if (pe) exp_q.push_back(pb);
        exp_q.push_back(1'b1);
`ifdef UART_TX_TWO_STOP_EN
        exp_q.push_back(1'b1);
`endif
        bus.P_DATA     = d;
        bus.PAR_EN     = pe;
        bus.par_bit    = pb;
        bus.DATA_VALID = 1'b1;
        for (int i = 0; i < exp_q.size(); i++) begin
            tick();
            check($sformatf("%s tx[%0d]", name, i), bus.TX_OUT, exp_q[i]);
            check($sformatf("%s busy[%0d]", name, i), bus.BUSY, 1'b1);
            if (!hold) bus.DATA_VALID = 1'b0;
            if (scramble) begin
                bus.P_DATA = (i == 0) ? {DW{1'b1}} : DW'($urandom);
                bus.PAR_EN = 1'($urandom);
                if (i >= 9) bus.par_bit = 1'($urandom);
            end
        end
        tick();
        check($sformatf("%s gap_tx", name), bus.TX_OUT, 1'b1);
        check($sformatf("%s gap_busy", name), bus.BUSY, 1'b0);
    endtask

    initial begin
        bus.P_DATA     = '0;
        bus.DATA_VALID = 1'b0;
        bus.PAR_EN     = 1'b0;
        bus.par_bit    = 1'b0;

        // Reset held, then released with no request
        #12;
        check("rst_tx", bus.TX_OUT, 1'b1);
        check("rst_busy", bus.BUSY, 1'b0);
        tick();
        RST = 1'b1;
        check_idle("post_rst", 4);

        // Directed frames from the test plan
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, "a5_par");
        check_idle("after_a5", 1);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, "3c_nopar");
        check_idle("after_3c", 1);
        send_frame(8'h01, 1'b1, 1'b1, 1'b0, 1'b1, "b2b_01");
        send_frame(8'h80, 1'b1, 1'b1, 1'b0, 1'b1, "b2b_80");
        bus.DATA_VALID = 1'b0;
        check_idle("after_b2b", 2);
`ifdef UART_TX_TWO_STOP_EN
        send_frame(8'h00, 1'b1, 1'b0, 1'b0, 1'b0, "two_stop_00");
        check_idle("after_two_stop", 1);
`endif

        // Asynchronous reset in the middle of a 0x55 frame
        bus.P_DATA     = 8'h55;
        bus.PAR_EN     = 1'b1;
        bus.par_bit    = 1'b0;
        bus.DATA_VALID = 1'b1;
        tick();
        check("abort start", bus.TX_OUT, 1'b0);
        bus.DATA_VALID = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("abort d%0d", i), bus.TX_OUT, ((i % 2) == 0) ? 1'b1 : 1'b0);
            check($sformatf("abort busy%0d", i), bus.BUSY, 1'b1);
        end
        #2;
        RST = 1'b0;
        #1;
        check("abort async_tx", bus.TX_OUT, 1'b1);
        check("abort async_busy", bus.BUSY, 1'b0);
        tick();
        check("abort held_tx", bus.TX_OUT, 1'b1);
        check("abort held_busy", bus.BUSY, 1'b0);
        #2;
        RST = 1'b1;
        check_idle("after_abort", 2);
        send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, "clean_55");

        // Randomized frames, with random gaps, scrambling and back-to-back
        for (int f = 0; f < 16; f++) begin
            logic [DW-1:0] d;
            logic pe, pb, scr, hold;
            d    = DW'($urandom);
            pe   = 1'($urandom);
            pb   = 1'($urandom);
            scr  = 1'($urandom);
            hold = (f < 15) ? 1'($urandom) : 1'b0;
            send_frame(d, pe, pb, scr, hold, $sformatf("rnd%0d", f));
            if (!hold) check_idle($sformatf("rnd%0d", f), $urandom_range(0, 2));
        end
        bus.DATA_VALID = 1'b0;
        check_idle("final", 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
